// File: rtl/lcd_init_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_init_seq_if
// Description : Control, init-ROM and 8080 LCD pin bundle for lcd_init_seq.
//               master = the sequencer, slave = controller/ROM/panel side.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_init_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH+1:0] rom_data;
  logic                  busy;
  logic                  done;
  logic                  lcd_cs;
  logic                  lcd_rs;
  logic                  lcd_wr;
  logic                  lcd_rd;
  logic [DATA_WIDTH-1:0] lcd_data;
  logic                  lcd_rst;
  logic                  lcd_bl;

  modport master (
    input  start, rom_data,
    output rom_addr, busy, done, lcd_cs, lcd_rs, lcd_wr, lcd_rd,
           lcd_data, lcd_rst, lcd_bl
  );

  modport slave (
    output start, rom_data,
    input  rom_addr, busy, done, lcd_cs, lcd_rs, lcd_wr, lcd_rd,
           lcd_data, lcd_rst, lcd_bl
  );
endinterface
`default_nettype wire

// File: rtl/lcd_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : lcd_init_seq
// Description : LCD panel init sequencer. Pulses the panel reset, waits, then
//               plays an external synchronous init ROM (CMD/DATA/DELAY/END)
//               onto an 8080-style write bus. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_init_seq #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int WR_LOW_CYC   = 2,
  parameter int WR_HIGH_CYC  = 2,
  parameter int DELAY_UNIT   = 50000,
  parameter int RST_LOW_CYC  = 500000,
  parameter int RST_WAIT_CYC = 6000000
) (
  input  wire            clk,
  input  wire            rst,
  lcd_init_seq_if.master io_bus
);

  // One shared down-counter covers every timed phase, so size it for the longest.
  localparam int c_MAX_A = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int c_MAX_B = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int c_MAX_C = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_MAX   = (c_MAX_C > DELAY_UNIT) ? c_MAX_C : DELAY_UNIT;
  localparam int c_CNT_W = $clog2(c_MAX + 1);

  // Counters are loaded with count-1 so each phase lasts exactly its count.
  localparam logic [c_CNT_W-1:0]    c_RST_LOW_LD  = c_CNT_W'(RST_LOW_CYC - 1);
  localparam logic [c_CNT_W-1:0]    c_RST_WAIT_LD = c_CNT_W'(RST_WAIT_CYC - 1);
  localparam logic [c_CNT_W-1:0]    c_WR_LOW_LD   = c_CNT_W'(WR_LOW_CYC - 1);
  localparam logic [c_CNT_W-1:0]    c_WR_HIGH_LD  = c_CNT_W'(WR_HIGH_CYC - 1);
  localparam logic [c_CNT_W-1:0]    c_UNIT_LD     = c_CNT_W'(DELAY_UNIT - 1);
  localparam logic [c_CNT_W-1:0]    c_CNT_ONE     = c_CNT_W'(1);
  localparam logic [DATA_WIDTH-1:0] c_TICK_ONE    = DATA_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE     = ADDR_WIDTH'(1);

  localparam logic [1:0] c_OP_CMD   = 2'b00;
  localparam logic [1:0] c_OP_DATA  = 2'b01;
  localparam logic [1:0] c_OP_DELAY = 2'b10;
  localparam logic [1:0] c_OP_END   = 2'b11;

  localparam logic [3:0] c_IDLE     = 4'd0;
  localparam logic [3:0] c_RST_LOW  = 4'd1;
  localparam logic [3:0] c_RST_WAIT = 4'd2;
  localparam logic [3:0] c_FETCH    = 4'd3;
  localparam logic [3:0] c_DECODE   = 4'd4;
  localparam logic [3:0] c_WR_LOW   = 4'd5;
  localparam logic [3:0] c_WR_HIGH  = 4'd6;
  localparam logic [3:0] c_DELAY    = 4'd7;
  localparam logic [3:0] c_ADVANCE  = 4'd8;
  localparam logic [3:0] c_DONE     = 4'd9;

  logic [3:0]            r_state;
  logic [3:0]            w_state_nxt;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0] r_tick;
  logic [ADDR_WIDTH-1:0] r_ptr;

  logic                  r_busy, r_done, r_cs, r_rs, r_wr, r_rst_n, r_bl;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_busy_nxt, w_done_nxt, w_cs_nxt, w_rs_nxt, w_wr_nxt;
  logic                  w_rst_n_nxt, w_bl_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;

  logic [1:0]            w_op;
  logic [DATA_WIDTH-1:0] w_payload;
  logic                  w_cnt_zero;
  logic                  w_tick_zero;
  logic                  w_ptr_last;

  assign w_op        = io_bus.rom_data[DATA_WIDTH+1:DATA_WIDTH];
  assign w_payload   = io_bus.rom_data[DATA_WIDTH-1:0];
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_tick_zero = (r_tick == '0);
  assign w_ptr_last  = &r_ptr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE, c_DONE: if (io_bus.start) w_state_nxt = c_RST_LOW;
      c_RST_LOW:      if (w_cnt_zero) w_state_nxt = c_RST_WAIT;
      c_RST_WAIT:     if (w_cnt_zero) w_state_nxt = c_FETCH;
      c_FETCH:        w_state_nxt = c_DECODE;
      c_DECODE: begin
        case (w_op)
          c_OP_CMD, c_OP_DATA: w_state_nxt = c_WR_LOW;
          c_OP_DELAY:          w_state_nxt = (w_payload == '0) ? c_ADVANCE : c_DELAY;
          c_OP_END:            w_state_nxt = c_DONE;
          default:             w_state_nxt = c_DONE;
        endcase
      end
      c_WR_LOW:  if (w_cnt_zero) w_state_nxt = c_WR_HIGH;
      c_WR_HIGH: if (w_cnt_zero) w_state_nxt = c_ADVANCE;
      c_DELAY:   if (w_cnt_zero && w_tick_zero) w_state_nxt = c_ADVANCE;
      // Last ROM address acts as an implicit END; the pointer never wraps.
      c_ADVANCE: w_state_nxt = w_ptr_last ? c_DONE : c_FETCH;
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  // Output next-values, derived from the state being entered so the
  // registered pins line up with the state they belong to.
  always_comb begin
    w_busy_nxt  = !((w_state_nxt == c_IDLE) || (w_state_nxt == c_DONE));
    w_done_nxt  = (w_state_nxt == c_DONE);
    w_bl_nxt    = (w_state_nxt == c_DONE);
    w_rst_n_nxt = (w_state_nxt != c_RST_LOW);
    w_wr_nxt    = (w_state_nxt != c_WR_LOW);
    w_cs_nxt    = r_cs;
    w_rs_nxt    = r_rs;
    w_data_nxt  = r_data;
    if ((r_state == c_DECODE) && (w_state_nxt == c_WR_LOW)) begin
      w_cs_nxt   = 1'b0;
      w_rs_nxt   = w_op[0];
      w_data_nxt = w_payload;
    end
    // Chip select stays low across back-to-back writes; only these release it.
    if ((w_state_nxt == c_DELAY) || (w_state_nxt == c_DONE) || (w_state_nxt == c_RST_LOW))
      w_cs_nxt = 1'b1;
  end

  // Output registers; async reset drives every pin to its idle level at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs    <= 1'b1;
      r_rs    <= 1'b1;
      r_wr    <= 1'b1;
      r_rst_n <= 1'b1;
      r_bl    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cs    <= w_cs_nxt;
      r_rs    <= w_rs_nxt;
      r_wr    <= w_wr_nxt;
      r_rst_n <= w_rst_n_nxt;
      r_bl    <= w_bl_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Phase/delay counters and ROM pointer; delay uses tick x unit counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= '0;
      r_ptr  <= '0;
    end else begin
      if (w_state_nxt != r_state) begin
        case (w_state_nxt)
          c_RST_LOW:  r_cnt <= c_RST_LOW_LD;
          c_RST_WAIT: r_cnt <= c_RST_WAIT_LD;
          c_WR_LOW:   r_cnt <= c_WR_LOW_LD;
          c_WR_HIGH:  r_cnt <= c_WR_HIGH_LD;
          c_DELAY:    r_cnt <= c_UNIT_LD;
          default:    r_cnt <= '0;
        endcase
        if (w_state_nxt == c_DELAY) r_tick <= w_payload - c_TICK_ONE;
      end else if ((r_state == c_DELAY) && w_cnt_zero && !w_tick_zero) begin
        r_cnt  <= c_UNIT_LD;
        r_tick <= r_tick - c_TICK_ONE;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - c_CNT_ONE;
      end

      if (r_state == c_RST_LOW)
        r_ptr <= '0;
      else if ((r_state == c_ADVANCE) && (w_state_nxt == c_FETCH))
        r_ptr <= r_ptr + c_PTR_ONE;
    end
  end

  assign io_bus.rom_addr = r_ptr;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign io_bus.lcd_cs   = r_cs;
  assign io_bus.lcd_rs   = r_rs;
  assign io_bus.lcd_wr   = r_wr;
  assign io_bus.lcd_rd   = 1'b1;
  assign io_bus.lcd_data = r_data;
  assign io_bus.lcd_rst  = r_rst_n;
  assign io_bus.lcd_bl   = r_bl;

endmodule
`default_nettype wire

// File: tb/tb_lcd_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_init_seq
// Description : Self-checking bench for lcd_init_seq. Expected strobes are
//               queued from a timing model of the ROM image and popped as the
//               panel-side strobes appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_init_seq;

  localparam int DW       = 16;
  localparam int RST_LOW  = 4;
  localparam int RST_WAIT = 3;
  localparam int WR_LOW   = 2;
  localparam int WR_HIGH  = 2;
  localparam int DU       = 4;

  typedef struct {
    logic        rs;
    logic [15:0] data;
    int          gap;
  } strobe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;

  lcd_init_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(8)) bus0 ();
  lcd_init_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) bus1 ();

  lcd_init_seq #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(8), .WR_LOW_CYC(WR_LOW), .WR_HIGH_CYC(WR_HIGH),
    .DELAY_UNIT(DU), .RST_LOW_CYC(RST_LOW), .RST_WAIT_CYC(RST_WAIT)
  ) u_dut0 (.clk(clk), .rst(rst), .io_bus(bus0));

  lcd_init_seq #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(2), .WR_LOW_CYC(WR_LOW), .WR_HIGH_CYC(WR_HIGH),
    .DELAY_UNIT(DU), .RST_LOW_CYC(RST_LOW), .RST_WAIT_CYC(RST_WAIT)
  ) u_dut1 (.clk(clk), .rst(rst), .io_bus(bus1));

  always #5 clk = ~clk;

  logic [17:0] rom0 [256];
  logic [17:0] rom1 [4];

  // Synchronous ROMs: data valid one cycle after the address.
  always @(posedge clk) bus0.rom_data <= rom0[bus0.rom_addr];
  always @(posedge clk) bus1.rom_data <= rom1[bus1.rom_addr];

  // Observation mux so one watcher serves both DUTs.
  logic        s_wr, s_cs, s_rs, s_rst_n, s_done, s_busy, s_bl, s_rd;
  logic [15:0] s_data;
  logic [7:0]  s_addr;
  always_comb begin
    s_wr = bus0.lcd_wr; s_cs = bus0.lcd_cs; s_rs = bus0.lcd_rs; s_rst_n = bus0.lcd_rst;
    s_done = bus0.done; s_busy = bus0.busy; s_bl = bus0.lcd_bl; s_rd = bus0.lcd_rd;
    s_data = bus0.lcd_data; s_addr = bus0.rom_addr;
    if (sel) begin
      s_wr = bus1.lcd_wr; s_cs = bus1.lcd_cs; s_rs = bus1.lcd_rs; s_rst_n = bus1.lcd_rst;
      s_done = bus1.done; s_busy = bus1.busy; s_bl = bus1.lcd_bl; s_rd = bus1.lcd_rd;
      s_data = bus1.lcd_data; s_addr = {6'b0, bus1.rom_addr};
    end
  end

  int      n_cmp = 0;
  int      n_bad = 0;
  strobe_t exp_q[$];
  int      exp_done;
  int      exp_cs_rises;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_addr"}, s_addr, 0);
    check({tag, "_busy"}, s_busy, 0);
    check({tag, "_done"}, s_done, 0);
    check({tag, "_cs"}, s_cs, 1);
    check({tag, "_rs"}, s_rs, 1);
    check({tag, "_wr"}, s_wr, 1);
    check({tag, "_rd"}, s_rd, 1);
    check({tag, "_data"}, s_data, 0);
    check({tag, "_lcd_rst"}, s_rst_n, 1);
    check({tag, "_bl"}, s_bl, 0);
  endtask

  // Timing model: cycle 0 = first cycle after lcd_rst releases.
  task automatic build_expect();
    int          t, prev, depth, p;
    logic        cs_low;
    logic [17:0] w;
    strobe_t     e;
    exp_q.delete();
    t = RST_WAIT; prev = 0; cs_low = 1'b0; exp_cs_rises = 0;
    depth = sel ? 4 : 256;
    for (p = 0; p < depth; p++) begin
      w = sel ? rom1[p] : rom0[p];
      if (w[17:16] == 2'b11) begin
        exp_done = t + 2;
        if (cs_low) exp_cs_rises++;
        return;
      end else if (w[17:16] == 2'b10) begin
        if (w[15:0] == 16'h0) t += 3;
        else begin
          t += 3 + int'(w[15:0]) * DU;
          if (cs_low) exp_cs_rises++;
          cs_low = 1'b0;
        end
      end else begin
        e.rs = w[16]; e.data = w[15:0]; e.gap = t + 2 - prev;
        exp_q.push_back(e);
        prev = t + 2;
        t += 3 + WR_LOW + WR_HIGH;
        cs_low = 1'b1;
      end
    end
    exp_done = t;
    if (cs_low) exp_cs_rises++;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    if (sel) bus1.start = 1'b1; else bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0; bus1.start = 1'b0;
  endtask

  // Follows one sequence, sampled on negedges, until done rises.
  task automatic watch(input int budget);
    int       rl_len, t_ref, last_start, low_cnt, cs_rises, addr_drops;
    logic     p_wr, p_cs, p_rst_n, p_done, rel, fin;
    logic [7:0] p_addr;
    strobe_t  cur;
    rl_len = 0; t_ref = 0; last_start = 0; low_cnt = 0; cs_rises = 0; addr_drops = 0;
    p_wr = 1'b1; p_cs = s_cs; p_rst_n = 1'b1; p_done = 1'b0; rel = 1'b0; fin = 1'b0;
    p_addr = s_addr;
    cur = '{1'b0, 16'h0, 0};
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      if (!s_rst_n) rl_len++;
      if (s_rst_n && !p_rst_n) begin
        check("rst_low_len", rl_len, RST_LOW);
        t_ref = cyc; last_start = cyc; rel = 1'b1;
      end
      if (rel && (s_addr < p_addr)) addr_drops++;
      if (!s_wr && p_wr) begin
        if (exp_q.size() == 0) check("extra_strobe", 1, 0);
        else begin
          cur = exp_q.pop_front();
          check("strobe_gap", cyc - last_start, cur.gap);
          check("strobe_rs", s_rs, cur.rs);
          check("strobe_data", s_data, cur.data);
          check("strobe_cs", s_cs, 0);
        end
        last_start = cyc; low_cnt = 1;
      end else if (!s_wr) begin
        low_cnt++;
      end else if (!p_wr) begin
        check("wr_low_len", low_cnt, WR_LOW);
        check("data_hold", s_data, cur.data);
        check("rs_hold", s_rs, cur.rs);
        check("cs_hold", s_cs, 0);
      end
      if (rel && s_cs && !p_cs) cs_rises++;
      if (s_done && !p_done) begin
        check("done_time", cyc - t_ref, exp_done);
        check("done_bl", s_bl, 1);
        check("done_cs", s_cs, 1);
        check("done_busy", s_busy, 0);
        check("cs_rises", cs_rises, exp_cs_rises);
        check("strobes_missing", exp_q.size(), 0);
        check("addr_wrap", addr_drops, 0);
        fin = 1'b1;
      end
      p_wr = s_wr; p_cs = s_cs; p_rst_n = s_rst_n; p_done = s_done; p_addr = s_addr;
      if (!fin) @(negedge clk);
    end
    if (!fin) check("done_timeout", 0, 1);
  endtask

  task automatic load_rom_a();
    for (int i = 0; i < 256; i++) rom0[i] = {2'b11, 16'h0};
    rom0[0] = {2'b00, 16'h0011};
    rom0[1] = {2'b01, 16'h00AB};
    rom0[2] = {2'b11, 16'h0000};
  endtask

  initial begin
    int   falls;
    logic pw;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    load_rom_a();
    for (int i = 0; i < 4; i++) rom1[i] = {2'b00, 16'hC0 + 16'(i)};

    // Outputs held at idle values during reset.
    #7;
    check_reset_vals("por");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    // Two writes then END.
    build_expect();
    pulse_start();
    watch(400);

    // Restart after done; a start pulse while busy must be ignored.
    build_expect();
    pulse_start();
    check("done_drop", s_done, 0);
    check("busy_rise", s_busy, 1);
    fork
      watch(400);
      begin
        repeat (12) @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
      end
    join

    // Delays: tick-based and zero-length.
    for (int i = 0; i < 256; i++) rom0[i] = {2'b11, 16'h0};
    rom0[0] = {2'b00, 16'h0001};
    rom0[1] = {2'b10, 16'h0003};
    rom0[2] = {2'b00, 16'h0029};
    rom0[3] = {2'b10, 16'h0000};
    rom0[4] = {2'b01, 16'h0055};
    rom0[5] = {2'b11, 16'h0000};
    build_expect();
    pulse_start();
    watch(400);

    // Full-depth ROM without END on the 2-bit-address instance.
    sel = 1'b1;
    build_expect();
    pulse_start();
    watch(400);
    sel = 1'b0;

    // Async reset during WR_LOW of the second write, then clean restart.
    load_rom_a();
    pulse_start();
    falls = 0; pw = 1'b1;
    for (int i = 0; i < 200 && falls < 2; i++) begin
      if (!s_wr && pw) falls++;
      pw = s_wr;
      if (falls < 2) @(negedge clk);
    end
    check("second_write_reached", falls, 2);
    #2 rst = 1'b1;
    #1 check_reset_vals("mid_rst");
    @(negedge clk); rst = 1'b0;
    build_expect();
    pulse_start();
    watch(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_init_seq.md
Name: lcd_init_seq

Overview:
- Parametrised LCD panel initialisation sequencer for the 8080-style parallel LCD bus.
- Generates the hardware reset pulse itself, then steps through an external synchronous init ROM.
- Each ROM entry is an opcode (command write, data write, timed delay, end) plus a payload.
- Sits between the system controller (start/done) and the LCD pins; the pixel writer takes the bus after done.

Parameters:
- DATA_WIDTH, 16, LCD data bus width (8 or 16).
- ADDR_WIDTH, 8, init ROM address width; ROM depth = 2**ADDR_WIDTH.
- WR_LOW_CYC, 2, clk cycles lcd_wr is held low per write (>=1).
- WR_HIGH_CYC, 2, clk cycles lcd_wr is held high after each write (>=1).
- DELAY_UNIT, 50000, clk cycles per delay tick (>=1).
- RST_LOW_CYC, 500000, clk cycles lcd_rst is held low during the hardware reset phase (>=1).
- RST_WAIT_CYC, 6000000, clk cycles to wait after lcd_rst is released (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins the sequence from IDLE or DONE
- rom_addr  out  ADDR_WIDTH  init ROM address
- rom_data  in  DATA_WIDTH+2  ROM word; valid one cycle after rom_addr; [DATA_WIDTH+1:DATA_WIDTH] = op, low bits = payload
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE; stays high until the next start
- lcd_cs  out  1  chip select, active low
- lcd_rs  out  1  0 = command, 1 = data
- lcd_wr  out  1  write strobe, active low; panel latches on the rising edge
- lcd_rd  out  1  tied 1
- lcd_data  out  DATA_WIDTH  bus data
- lcd_rst  out  1  panel reset, active low
- lcd_bl  out  1  backlight enable; set to 1 on entering DONE

Behaviour:
- Clocking and reset: one clock domain; async active-high rst.
- Output values while rst is asserted, and immediately after: state IDLE, rom_addr=0, busy=0, done=0, lcd_cs=1, lcd_rs=1, lcd_wr=1, lcd_rd=1, lcd_data=0, lcd_rst=1, lcd_bl=0. All outputs are registered.
- Reset mid-sequence aborts immediately to these values with no partial strobe completion. lcd_wr rises asynchronously with rst.
- Opcodes: 00 CMD (rs=0), 01 DATA (rs=1), 10 DELAY (payload = tick count), 11 END.
- State machine:
  - IDLE / DONE: start -> RST_LOW. Other inputs are ignored. Start while busy is ignored.
  - RST_LOW: lcd_rst=0 for RST_LOW_CYC cycles -> RST_WAIT. In this state ptr is cleared, done=0, lcd_bl=0.
  - RST_WAIT: lcd_rst=1 for RST_WAIT_CYC cycles -> FETCH.
  - FETCH (1 cycle): rom_addr=ptr -> DECODE.
  - DECODE (1 cycle), on rom_data:
    - CMD/DATA: register payload to lcd_data, set lcd_rs, lcd_cs=0 -> WR_LOW.
    - DELAY, payload 0: treated as NOP -> ADVANCE.
    - DELAY, payload nonzero: -> DELAY.
    - END: lcd_cs=1 -> DONE.
  - WR_LOW: lcd_wr=0 for WR_LOW_CYC cycles; data and rs stable -> WR_HIGH.
  - WR_HIGH: lcd_wr=1 for WR_HIGH_CYC cycles; cs stays low; data and rs stay stable through the rising edge -> ADVANCE.
  - DELAY: wait payload*DELAY_UNIT cycles. lcd_cs=1. Separate tick and unit counters are used (no multiplier) -> ADVANCE.
  - ADVANCE (1 cycle):
    - ptr == 2**ADDR_WIDTH-1: implicit END; lcd_cs=1 -> DONE. No wrap-around to 0.
    - Otherwise: ptr+1 -> FETCH.
- Write cost: 3+WR_LOW_CYC+WR_HIGH_CYC cycles per entry (FETCH, DECODE, ADVANCE plus the strobe).
- Entering DONE: done=1, lcd_bl=1, busy=0.
- Back-to-back writes: lcd_cs remains low from one write into the next write's FETCH/DECODE. It returns high only in DELAY and DONE.
- Counters size themselves from the parameters with $clog2 and saturate at zero. There is no off-by-one: each phase lasts exactly its parameter count.

Test Plan:
- Assert rst mid-cycle -> all outputs take their reset values asynchronously; lcd_rd=1 always.
- Params RST_LOW_CYC=4, RST_WAIT_CYC=3, WR_LOW_CYC=2, WR_HIGH_CYC=2. ROM {CMD 0x0011, DATA 0x00AB, END}. start -> lcd_rst low exactly 4 cycles, then 3 cycles high. Then two strobes: 0x0011 with rs=0, 0x00AB with rs=1, each wr-low for 2 cycles, with 7 cycles between strobe starts. Then done=1, lcd_bl=1, lcd_cs=1.
- DELAY_UNIT=4, ROM {DELAY 3, CMD 0x29, END} -> exactly 12 cycles in DELAY with lcd_cs=1 before the 0x29 strobe. DELAY 0 -> no delay, next entry fetched after ADVANCE.
- start pulsed while busy -> ignored; sequence and timing unchanged. start after done -> done drops, full sequence reruns from address 0.
- ADDR_WIDTH=2, ROM of 4 CMD entries with no END -> exactly 4 strobes; DONE entered after address 3; rom_addr never wraps to 0.
- rst asserted during WR_LOW of the second write, then released, then start -> restart from address 0; first strobe carries ROM[0].
